// File: rtl/vae_fxp_pkg.sv
// -----------------------------------------------------------------------------
// vae_fxp_pkg
//   Shared definitions for the VAE fixed-point operators (divider and
//   multiplier users): divider FSM state encoding, default Q-format widths and
//   per-width saturation limits.
//   Ports: none (package).
// -----------------------------------------------------------------------------
package vae_fxp_pkg;

    localparam int FXP_WIDTH_DEF      = 16;
    localparam int FXP_FRAC_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } fxp_div_state_e;

    // Largest positive two's-complement value of the given width, returned in
    // the low bits of a 64-bit word.
    function automatic logic [63:0] fxp_max(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of the given width (bit pattern
    // 100..0 in the low bits).
    function automatic logic [63:0] fxp_min(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/fxp_div_if.sv
// -----------------------------------------------------------------------------
// fxp_div_if
//   Operand/result handshake bundle for the fixed-point divider.
//   Signals:
//     in_valid, in_ready      operand handshake
//     dividend, divisor       signed Q-format operands
//     out_valid, out_ready    result handshake
//     quotient, div_by_zero   signed Q-format result and divide-by-zero flag
//   Modports: master (operand producer / result consumer), slave (divider).
// -----------------------------------------------------------------------------
interface fxp_div_if #(
    parameter int WIDTH = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic             div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, div_by_zero
    );

endinterface

// File: rtl/fxp_div_step.sv
// -----------------------------------------------------------------------------
// fxp_div_step
//   One combinational restoring-division step: shift the next numerator bit
//   into the partial remainder, subtract the divisor magnitude when it fits.
//   Ports:
//     rem_in   [WIDTH+1:0]  partial remainder before this step
//     num_bit               next numerator bit (MSB first)
//     div_mag  [WIDTH:0]    divisor magnitude
//     rem_out  [WIDTH+1:0]  partial remainder after this step
//     q_bit                 quotient bit produced by this step
// -----------------------------------------------------------------------------
module fxp_div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH+1:0] rem_in,
    input  logic             num_bit,
    input  logic [WIDTH:0]   div_mag,
    output logic [WIDTH+1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH+2:0] trial;
    logic [WIDTH+1:0] diff;

    always_comb begin
        trial   = {rem_in, num_bit};
        // The full-width compare keeps the shifted-out MSB in play; the
        // subtraction only needs the low bits since the result is < div_mag.
        q_bit   = (trial >= {2'b00, div_mag});
        diff    = trial[WIDTH+1:0] - {1'b0, div_mag};
        rem_out = q_bit ? diff : trial[WIDTH+1:0];
    end

endmodule

// File: rtl/fxp_div.sv
// -----------------------------------------------------------------------------
// fxp_div
//   Iterative signed fixed-point divider, quotient = dividend / divisor in the
//   same two's-complement Q format. Restoring division, one quotient bit per
//   clock, WIDTH+FRAC_WIDTH iterations, fixed latency.
//   Ports:
//     clk    clock, rising edge
//     rst_n  asynchronous reset, active low
//     bus    fxp_div_if.slave: in_valid/in_ready/dividend/divisor,
//            out_valid/out_ready/quotient/div_by_zero
//   Build option: define FXP_DIV_SAT_EN to saturate out-of-range quotients
//   instead of wrapping to the low WIDTH bits.
//
//   state | meaning
//   IDLE  | in_ready=1, waiting for operands
//   CALC  | one restoring step per edge, N steps
//   FIX   | apply sign / divide-by-zero / saturation, register result
//   DONE  | out_valid=1, result held until out_ready
// -----------------------------------------------------------------------------
module fxp_div
    import vae_fxp_pkg::*;
#(
    parameter int WIDTH      = FXP_WIDTH_DEF,
    parameter int FRAC_WIDTH = FXP_FRAC_WIDTH_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    fxp_div_if.slave   bus
);

    localparam int N  = WIDTH + FRAC_WIDTH;
    localparam int CW = $clog2(N) + 1;

    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(fxp_max(WIDTH));
    localparam logic [WIDTH-1:0] Q_MIN = WIDTH'(fxp_min(WIDTH));
`ifdef FXP_DIV_SAT_EN
    localparam logic [N-1:0] POS_LIM = N'(fxp_max(WIDTH));
    localparam logic [N-1:0] NEG_LIM = N'(fxp_min(WIDTH));
`endif

    fxp_div_state_e   state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH+1:0] rem_q, rem_d;
    logic [N-1:0]     num_q, num_d;
    logic [N-1:0]     q_mag_q, q_mag_d;
    logic [WIDTH:0]   div_mag_q, div_mag_d;
    logic             sign_q, sign_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic             div_by_zero_q, div_by_zero_d;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH+1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] q_low;

    // Magnitudes as unsigned WIDTH-bit values: negating 100..0 yields 100..0,
    // which read as unsigned is exactly 2^(WIDTH-1), so no extra bit is needed.
    assign dvd_mag = bus.dividend[WIDTH-1] ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
    assign dvs_mag = bus.divisor[WIDTH-1]  ? (~bus.divisor  + WIDTH'(1)) : bus.divisor;
    assign q_low   = q_mag_q[WIDTH-1:0];

    fxp_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_q),
        .num_bit (num_q[N-1]),
        .div_mag (div_mag_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            rem_q         <= '0;
            num_q         <= '0;
            q_mag_q       <= '0;
            div_mag_q     <= '0;
            sign_q        <= 1'b0;
            dbz_q         <= 1'b0;
            quotient_q    <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            num_q         <= num_d;
            q_mag_q       <= q_mag_d;
            div_mag_q     <= div_mag_d;
            sign_q        <= sign_d;
            dbz_q         <= dbz_d;
            quotient_q    <= quotient_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        num_d         = num_q;
        q_mag_d       = q_mag_q;
        div_mag_d     = div_mag_q;
        sign_d        = sign_q;
        dbz_d         = dbz_q;
        quotient_d    = quotient_q;
        div_by_zero_d = div_by_zero_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    sign_d    = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                    num_d     = {dvd_mag, {FRAC_WIDTH{1'b0}}};
                    div_mag_d = {1'b0, dvs_mag};
                    rem_d     = '0;
                    q_mag_d   = '0;
                    cnt_d     = '0;
                    dbz_d     = (bus.divisor == '0);
                    state_d   = ST_CALC;
                end
            end
            ST_CALC: begin
                rem_d   = step_rem;
                q_mag_d = {q_mag_q[N-2:0], step_q};
                num_d   = {num_q[N-2:0], 1'b0};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                // With a zero divisor the sign is the dividend's own sign.
                if (dbz_q) begin
                    quotient_d = sign_q ? Q_MIN : Q_MAX;
`ifdef FXP_DIV_SAT_EN
                end else if (!sign_q && (q_mag_q > POS_LIM)) begin
                    quotient_d = Q_MAX;
                end else if (sign_q && (q_mag_q > NEG_LIM)) begin
                    quotient_d = Q_MIN;
`endif
                end else begin
                    // Low bits of a negation depend only on low bits, so the
                    // wrap result needs just the bottom WIDTH bits.
                    quotient_d = sign_q ? (~q_low + WIDTH'(1)) : q_low;
                end
                div_by_zero_d = dbz_q;
                cnt_d         = '0;
                state_d       = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.in_ready    = (state_q == ST_IDLE);
    assign bus.out_valid   = (state_q == ST_DONE);
    assign bus.quotient    = quotient_q;
    assign bus.div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_fxp_div.sv
module tb_fxp_div;

    localparam int WIDTH   = 16;
    localparam int FRAC    = 8;
    localparam int LATENCY = WIDTH + FRAC + 1;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fxp_div_if #(.WIDTH(WIDTH)) bus ();

    fxp_div #(
        .WIDTH      (WIDTH),
        .FRAC_WIDTH (FRAC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: real-valued quotient of the two Q numbers, truncated toward
    // zero, then wrapped (or saturated) to WIDTH bits.
    function automatic logic [15:0] ref_quot(input logic [15:0] a, input logic [15:0] b);
        longint n;
        longint d;
        longint q;
        n = longint'($signed(a)) * 256;
        d = longint'($signed(b));
        if (d == 0) return a[15] ? 16'h8000 : 16'h7FFF;
        q = n / d;
`ifdef FXP_DIV_SAT_EN
        if (q > 32767)  return 16'h7FFF;
        if (q < -32768) return 16'h8000;
`endif
        return q[15:0];
    endfunction

    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!bus.in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_before_start", {31'd0, bus.in_ready}, 32'd1);
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] exp_q, input logic exp_z);
        int lat;
        start_op(a, b);
        wait_result(lat);
        check({tag, "_latency"}, lat, LATENCY);
        check({tag, "_quot"}, {16'd0, bus.quotient}, {16'd0, exp_q});
        check({tag, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, exp_z});
        handshake();
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp4a;
        logic [15:0] exp4b;
        int          lat;

        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b0;

        #22;
        check("rst_in_ready",  {31'd0, bus.in_ready},    32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid},   32'd0);
        check("rst_quot",      {16'd0, bus.quotient},    32'd0);
        check("rst_dbz",       {31'd0, bus.div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed values
        run_op("t1",  16'h0300, 16'h0200, 16'h0180, 1'b0);
        run_op("t2a", 16'hFD00, 16'h0200, 16'hFE80, 1'b0);
        run_op("t2b", 16'h0100, 16'h0300, 16'h0055, 1'b0);
        run_op("t2c", 16'hFF00, 16'h0300, 16'hFFAB, 1'b0);
        run_op("t3a", 16'h0500, 16'h0000, 16'h7FFF, 1'b1);
        run_op("t3b", 16'hFB00, 16'h0000, 16'h8000, 1'b1);
`ifdef FXP_DIV_SAT_EN
        exp4a = 16'h7FFF;
        exp4b = 16'h8000;
`else
        exp4a = 16'hFE00;
        exp4b = 16'h0000;
`endif
        run_op("t4a", 16'h7F00, 16'h0080, exp4a, 1'b0);
        run_op("t4b", 16'h8000, 16'h0080, exp4b, 1'b0);

        // Result held in DONE while out_ready low; a stray in_valid is ignored
        start_op(16'h0300, 16'h0200);
        wait_result(lat);
        check("t5_latency", lat, LATENCY);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) begin
                bus.dividend = 16'h0700;
                bus.divisor  = 16'h0100;
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            check("t5_hold_quot",      {16'd0, bus.quotient}, 32'h0180);
            check("t5_hold_in_ready",  {31'd0, bus.in_ready}, 32'd0);
            check("t5_hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
        end
        bus.in_valid = 1'b0;
        handshake();
        check("t5_post_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("t5_post_out_valid", {31'd0, bus.out_valid}, 32'd0);
        run_op("t5_next", 16'h0100, 16'h0300, 16'h0055, 1'b0);

        // Reset in the middle of a calculation
        start_op(16'h0500, 16'h0300);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_in_ready",  {31'd0, bus.in_ready},    32'd1);
        check("t6_out_valid", {31'd0, bus.out_valid},   32'd0);
        check("t6_quot",      {16'd0, bus.quotient},    32'd0);
        check("t6_dbz",       {31'd0, bus.div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("t6_after", 16'h0300, 16'h0200, 16'h0180, 1'b0);

        // Randomized operands against the reference model
        for (int k = 0; k < 40; k++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 4))
                0:       b = 16'($urandom);
                1:       b = 16'($urandom_range(1, 16'h03FF));
                2:       b = 16'(-$urandom_range(1, 16'h03FF));
                3:       b = 16'($urandom_range(16'h0100, 16'h7FFF));
                default: b = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'h8000;
            endcase
            run_op("rnd", a, b, ref_quot(a, b), (b == 16'h0000));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
